// File: rtl/l1d_way_store_if.sv
// Controller-side bundle for the L1D way store: array access, PLRU update and victim select.
// The controller owns the master modport; the storage core owns the slave modport.
interface l1d_way_store_if #(
   parameter int unsigned SETS  = 64,
   parameter int unsigned WAYS  = 8,
   parameter int unsigned WORDS = 8,
   parameter int unsigned TAG_W = 52
);
   localparam int unsigned IdxW  = $clog2(SETS);
   localparam int unsigned WayW  = $clog2(WAYS);
   localparam int unsigned WordW = $clog2(WORDS);

   logic                    invalidate_all_i;
   logic [IdxW-1:0]         index_i;
   logic [WordW-1:0]        word_sel_i;
   logic [WayW-1:0]         way_sel_i;
   logic                    write_en_i;
   logic                    set_valid_i;
   logic                    set_dirty_i;
   logic [7:0]              be_i;
   logic [TAG_W-1:0]        tag_in_i;
   logic [63:0]             wdata_i;
   logic [63:0]             rdata_selected_o;
   logic [TAG_W-1:0]        tag_selected_o;
   logic                    valid_selected_o;
   logic                    dirty_selected_o;
   logic [WAYS*64-1:0]      rdata_way_flat_o;
   logic [WAYS*TAG_W-1:0]   tag_way_flat_o;
   logic [WAYS-1:0]         valid_way_o;
   logic [WAYS-1:0]         dirty_way_o;
   logic [IdxW-1:0]         plru_set_i;
   logic                    plru_access_i;
   logic [WayW-1:0]         plru_used_way_i;
   logic [WayW-1:0]         victim_o;

   modport master (
      output invalidate_all_i, index_i, word_sel_i, way_sel_i, write_en_i, set_valid_i,
             set_dirty_i, be_i, tag_in_i, wdata_i, plru_set_i, plru_access_i, plru_used_way_i,
      input  rdata_selected_o, tag_selected_o, valid_selected_o, dirty_selected_o,
             rdata_way_flat_o, tag_way_flat_o, valid_way_o, dirty_way_o, victim_o
   );

   modport slave (
      input  invalidate_all_i, index_i, word_sel_i, way_sel_i, write_en_i, set_valid_i,
             set_dirty_i, be_i, tag_in_i, wdata_i, plru_set_i, plru_access_i, plru_used_way_i,
      output rdata_selected_o, tag_selected_o, valid_selected_o, dirty_selected_o,
             rdata_way_flat_o, tag_way_flat_o, valid_way_o, dirty_way_o, victim_o
   );
endinterface

// File: rtl/l1d_way_store.sv
// L1 D$ storage core: data/tag/valid/dirty arrays with combinational reads, byte-masked
// synchronous writes, and a per-set 8-way tree pseudo-LRU with victim selection.
module l1d_way_store #(
   parameter int unsigned SETS  = 64,
   parameter int unsigned WAYS  = 8,
   parameter int unsigned WORDS = 8,
   parameter int unsigned TAG_W = 52
) (
   input logic            clk_i,
   input logic            rst_i,
   l1d_way_store_if.slave ctrl_io
);
   localparam int unsigned IdxW  = $clog2(SETS);
   localparam int unsigned WayW  = $clog2(WAYS);
   localparam int unsigned WordW = $clog2(WORDS);
   localparam int unsigned PlruW = WAYS - 1;

   logic [63:0]       data_q  [SETS][WAYS][WORDS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   valid_d [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [WAYS-1:0]   dirty_d [SETS];
   logic [PlruW-1:0]  plru_q  [SETS];
   logic [PlruW-1:0]  plru_d  [SETS];

   logic [IdxW-1:0]   idx;
   logic [WayW-1:0]   way;
   logic [WordW-1:0]  word;
   logic [WayW-1:0]   used_way;
   logic [PlruW-1:0]  node;
   logic              v2, v1, v0;
   logic [WayW-1:0]   victim;

   assign idx      = ctrl_io.index_i;
   assign way      = ctrl_io.way_sel_i;
   assign word     = ctrl_io.word_sel_i;
   assign used_way = ctrl_io.plru_used_way_i;

   // Data and tag carry no reset; only the write strobe (held off by reset) updates them.
   always_ff @(posedge clk_i) begin
      if (!rst_i && ctrl_io.write_en_i) begin
         tag_q[idx][way] <= ctrl_io.tag_in_i;
         for (int b = 0; b < 8; b++) begin
            if (ctrl_io.be_i[b]) begin
               data_q[idx][way][word][b*8 +: 8] <= ctrl_io.wdata_i[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      plru_d  = plru_q;
      if (ctrl_io.write_en_i) begin
         valid_d[idx][way] = ctrl_io.set_valid_i;
         dirty_d[idx][way] = ctrl_io.set_dirty_i;
      end
      if (ctrl_io.invalidate_all_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            dirty_d[s] = '0;
         end
      end
      // Point every node on the used way's path away from it; tree layout assumes 8 ways.
      if (ctrl_io.plru_access_i) begin
         plru_d[ctrl_io.plru_set_i][0]                            = ~used_way[2];
         plru_d[ctrl_io.plru_set_i][3'd1 + {2'b00, used_way[2]}]  = ~used_way[1];
         plru_d[ctrl_io.plru_set_i][3'd3 + {1'b0, used_way[2:1]}] = ~used_way[0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         plru_q  <= plru_d;
      end
   end

   always_comb begin
      ctrl_io.rdata_way_flat_o = '0;
      ctrl_io.tag_way_flat_o   = '0;
      for (int w = 0; w < WAYS; w++) begin
         ctrl_io.rdata_way_flat_o[w*64 +: 64]      = data_q[idx][w][word];
         ctrl_io.tag_way_flat_o[w*TAG_W +: TAG_W]  = tag_q[idx][w];
      end
      ctrl_io.valid_way_o      = valid_q[idx];
      ctrl_io.dirty_way_o      = dirty_q[idx];
      ctrl_io.rdata_selected_o = data_q[idx][way][word];
      ctrl_io.tag_selected_o   = tag_q[idx][way];
      ctrl_io.valid_selected_o = valid_q[idx][way];
      ctrl_io.dirty_selected_o = dirty_q[idx][way];
   end

   // An empty way always wins over the tree; the downward scan leaves the lowest one.
   always_comb begin
      node   = plru_q[idx];
      v2     = node[0];
      v1     = node[3'd1 + {2'b00, v2}];
      v0     = node[3'd3 + {1'b0, v2, v1}];
      victim = {v2, v1, v0};
      if (!(&valid_q[idx])) begin
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
               victim = WayW'(w);
            end
         end
      end
      ctrl_io.victim_o = victim;
   end
endmodule

// File: tb/tb_l1d_way_store.sv
// Directed bench for l1d_way_store: expectations are queued as stimulus is driven and
// popped against the DUT outputs after each step settles.
module tb_l1d_way_store;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   l1d_way_store_if bus ();

   l1d_way_store dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .ctrl_io (bus)
   );

   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic expect_val(input logic [63:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [63:0] obs);
      logic [63:0] exp;
      n_checks++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s: observed %h but no expected value queued", tag, obs);
         return;
      end
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] idx, input logic [2:0] w, input logic [2:0] wd,
                     input logic [63:0] data, input logic [7:0] be, input logic [51:0] tag,
                     input logic v, input logic d);
      bus.index_i     = idx;
      bus.way_sel_i   = w;
      bus.word_sel_i  = wd;
      bus.wdata_i     = data;
      bus.be_i        = be;
      bus.tag_in_i    = tag;
      bus.set_valid_i = v;
      bus.set_dirty_i = d;
      bus.write_en_i  = 1'b1;
      tick();
      bus.write_en_i  = 1'b0;
      #1;
   endtask

   task automatic touch(input logic [5:0] set, input logic [2:0] w);
      bus.plru_set_i      = set;
      bus.plru_used_way_i = w;
      bus.plru_access_i   = 1'b1;
      tick();
      bus.plru_access_i   = 1'b0;
      #1;
   endtask

   initial begin
      bus.invalidate_all_i = 1'b0;
      bus.index_i          = '0;
      bus.word_sel_i       = '0;
      bus.way_sel_i        = '0;
      bus.write_en_i       = 1'b0;
      bus.set_valid_i      = 1'b0;
      bus.set_dirty_i      = 1'b0;
      bus.be_i             = '0;
      bus.tag_in_i         = '0;
      bus.wdata_i          = '0;
      bus.plru_set_i       = '0;
      bus.plru_access_i    = 1'b0;
      bus.plru_used_way_i  = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state
      bus.index_i = 6'd0;
      #1;
      expect_val(64'h0); check("rst_valid", 64'(bus.valid_way_o));
      expect_val(64'h0); check("rst_dirty", 64'(bus.dirty_way_o));
      expect_val(64'h0); check("rst_victim", 64'(bus.victim_o));
      bus.index_i = 6'd33;
      #1;
      expect_val(64'h0); check("rst_valid33", 64'(bus.valid_way_o));

      // Byte merge
      wr(6'd5, 3'd3, 3'd2, 64'h1111_2222_3333_4444, 8'hFF, 52'hABC, 1'b1, 1'b0);
      wr(6'd5, 3'd3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 52'hABC, 1'b1, 1'b1);
      expect_val(64'h1111_2222_FFFF_FFFF); check("merge_rdata", bus.rdata_selected_o);
      expect_val(64'hABC); check("merge_tag", 64'(bus.tag_selected_o));
      expect_val(64'h08); check("merge_valid", 64'(bus.valid_way_o));
      expect_val(64'h08); check("merge_dirty", 64'(bus.dirty_way_o));
      expect_val(64'h1111_2222_FFFF_FFFF); check("merge_flat", bus.rdata_way_flat_o[255:192]);
      expect_val(64'hABC); check("merge_tag_flat", 64'(bus.tag_way_flat_o[207:156]));

      // Lowest invalid way as victim, then global invalidate
      for (int w = 0; w < 3; w++) begin
         wr(6'd7, 3'(w), 3'd0, 64'(w), 8'hFF, 52'(w + 16), 1'b1, 1'b1);
      end
      expect_val(64'h3); check("inv_way_victim", 64'(bus.victim_o));
      bus.invalidate_all_i = 1'b1;
      tick();
      bus.invalidate_all_i = 1'b0;
      #1;
      expect_val(64'h0); check("inval_valid", 64'(bus.valid_way_o));
      expect_val(64'h0); check("inval_dirty", 64'(bus.dirty_way_o));
      expect_val(64'h0); check("inval_victim", 64'(bus.victim_o));
      bus.index_i = 6'd5;
      #1;
      expect_val(64'h0); check("inval_other_set", 64'(bus.valid_way_o));

      // Tree PLRU on a full set
      for (int w = 0; w < 8; w++) begin
         wr(6'd9, 3'(w), 3'd0, 64'(w) * 64'h0101, 8'hFF, 52'(w + 32), 1'b1, 1'b0);
      end
      expect_val(64'hFF); check("plru_full", 64'(bus.valid_way_o));
      expect_val(64'h0); check("plru_init", 64'(bus.victim_o));
      touch(6'd9, 3'd0);
      expect_val(64'h4); check("plru_after0", 64'(bus.victim_o));
      touch(6'd9, 3'd4);
      expect_val(64'h2); check("plru_after4", 64'(bus.victim_o));
      touch(6'd9, 3'd2);
      expect_val(64'h6); check("plru_after2", 64'(bus.victim_o));
      touch(6'd10, 3'd6);
      touch(6'd10, 3'd1);
      expect_val(64'h6); check("plru_other_set", 64'(bus.victim_o));

      // Read-during-write, then clean-invalidate
      wr(6'd9, 3'd5, 3'd4, 64'hAAAA_0000_5555_1234, 8'hFF, 52'h55, 1'b1, 1'b0);
      bus.wdata_i    = 64'h0123_4567_89AB_CDEF;
      bus.be_i       = 8'hFF;
      bus.write_en_i = 1'b1;
      #1;
      expect_val(64'hAAAA_0000_5555_1234); check("rdw_old", bus.rdata_selected_o);
      tick();
      bus.write_en_i = 1'b0;
      #1;
      expect_val(64'h0123_4567_89AB_CDEF); check("rdw_new", bus.rdata_selected_o);
      wr(6'd9, 3'd5, 3'd4, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 52'h55, 1'b0, 1'b0);
      expect_val(64'hDF); check("clean_inv_valid", 64'(bus.valid_way_o));
      expect_val(64'h0123_4567_89AB_CDEF); check("clean_inv_data", bus.rdata_selected_o);
      expect_val(64'h5); check("clean_inv_victim", 64'(bus.victim_o));

      // Same-cycle write and PLRU update both land
      bus.plru_set_i      = 6'd9;
      bus.plru_used_way_i = 3'd6;
      bus.plru_access_i   = 1'b1;
      wr(6'd9, 3'd5, 3'd4, 64'h0, 8'h00, 52'h55, 1'b1, 1'b1);
      bus.plru_access_i   = 1'b0;
      #1;
      expect_val(64'h1); check("both_victim", 64'(bus.victim_o));
      expect_val(64'h20); check("both_dirty", 64'(bus.dirty_way_o));

      // Reset mid-sequence
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      expect_val(64'h0); check("rst2_valid", 64'(bus.valid_way_o));
      expect_val(64'h0); check("rst2_dirty", 64'(bus.dirty_way_o));
      expect_val(64'h0); check("rst2_victim", 64'(bus.victim_o));
      for (int w = 0; w < 8; w++) begin
         wr(6'd9, 3'(w), 3'd0, 64'h0, 8'h00, 52'h0, 1'b1, 1'b0);
      end
      expect_val(64'h0); check("rst2_plru", 64'(bus.victim_o));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
